// File: rtl/leg_uop_pkg.sv
// leg_uop_pkg: shared types and helpers for the decode-stage micro-op expander.
// Holds the sequencer state enum, instruction field positions, opcode and NOP
// encodings, and the LDM/STM micro-op builders.
package leg_uop_pkg;

  localparam int WORD_BYTES = 4;
  localparam int NREGS      = 16;
  localparam int IDX_W      = $clog2(NREGS);
  localparam int CNT_W      = $clog2(NREGS + 1);
  localparam int PC_IDX     = 15;

  typedef enum logic [2:0] {
    READY = 3'd0,
    RSR2  = 3'd1,
    XFER  = 3'd2,
    BASE  = 3'd3,
    WB    = 3'd4,
    PCLD  = 3'd5
  } uopState_t;

  // Instruction-class field and single-bit positions
  localparam int CLASS_HI = 27;
  localparam int CLASS_LO = 25;
  localparam logic [2:0] CLASS_DP  = 3'b000;
  localparam logic [2:0] CLASS_BLK = 3'b100;
  localparam int BIT_P   = 24;
  localparam int BIT_U   = 23;
  localparam int BIT_W   = 21;
  localparam int BIT_L   = 20;
  localparam int BIT_S   = 20;
  localparam int BIT_MUL = 7;
  localparam int BIT_RS  = 4;

  localparam logic [3:0]  OP_ADD   = 4'b0100;
  localparam logic [3:0]  OP_SUB   = 4'b0010;
  localparam logic [27:0] NOP_BODY = 28'h1A00000;  // MOV R0,R0 without cond

  function automatic logic [CNT_W-1:0] popCount(input logic [NREGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Byte offset from the original base for the register of the given rank
  // (0-based, ascending) in an n-register transfer.
  function automatic logic [11:0] blkOffset(input logic p, input logic u,
                                            input logic [CNT_W-1:0] n,
                                            input logic [CNT_W-1:0] rank);
    int words;
    if (u) words = int'(rank) + (p ? 1 : 0);
    else   words = int'(n) - int'(rank) - (p ? 0 : 1);
    return 12'(words * WORD_BYTES);
  endfunction

  // Single pre-indexed LDR/STR without writeback for register rd of a block transfer.
  function automatic logic [31:0] blkXferUop(input logic [31:0] instr,
                                             input logic [IDX_W-1:0] rd);
    logic [NREGS-1:0] list;
    logic [NREGS-1:0] below;
    list  = instr[NREGS-1:0];
    below = (NREGS'(1) << rd) - NREGS'(1);
    return {instr[31:28], 3'b010, 1'b1, instr[BIT_U], 2'b00, instr[BIT_L],
            instr[19:16], rd,
            blkOffset(instr[BIT_P], instr[BIT_U], popCount(list), popCount(list & below))};
  endfunction

  // Base update: Rn = Rn +/- n*WORD_BYTES
  function automatic logic [31:0] blkWbUop(input logic [31:0] instr);
    return {instr[31:28], 3'b001, (instr[BIT_U] ? OP_ADD : OP_SUB), 1'b0,
            instr[19:16], instr[19:16], 4'b0000,
            8'(int'(popCount(instr[NREGS-1:0])) * WORD_BYTES)};
  endfunction

endpackage

// File: rtl/uop_reglist_picker.sv
// uop_reglist_picker: lowest-set-bit priority encoder over the remaining
// register mask. Returns the index, a valid flag and the mask with that bit cleared.
module uop_reglist_picker
  import leg_uop_pkg::*;
(
  input  logic [NREGS-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [NREGS-1:0] maskRest
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign valid    = |mask;
  assign maskRest = mask & (mask - NREGS'(1));

endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: decode-stage micro-op expander between the F/D register and
// the controller. RSR data processing is split into two passes; with
// UOP_LDM_STM_EN defined, LDM/STM is split into single transfers plus base
// writeback. Without UOP_LDM_STM_EN block transfers pass through unchanged.
// The first micro-op of every sequence is emitted from READY.
//
// state | meaning
// READY | idle; first micro-op of any instruction
// RSR2  | second half of a register-shifted-register pair
// XFER  | listed transfers in ascending register order
// BASE  | deferred load of the base register
// WB    | base writeback add/sub
// PCLD  | deferred load of R15
module uop_sequencer
  import leg_uop_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] uOpInstrD,
  output logic        doNotUpdateFlagD,
  output logic        prevRSRstateD,
  output logic        uOpStallD,
  output logic        uOpActiveD
);

  uopState_t state, stateNext, stage;
  logic      isRsr;

  assign isRsr = (InstrD[CLASS_HI:CLASS_LO] == CLASS_DP) && InstrD[BIT_RS] && !InstrD[BIT_MUL];

`ifdef UOP_LDM_STM_EN
  logic [NREGS-1:0] maskQ, maskNext, regList, xferList, pickIn, pickRest;
  logic [IDX_W-1:0] pickIdx, emitRd;
  logic             pickValid, emitXfer, emitWb;
  logic             isBlk, blkL, blkW, needBase, needWb, needPc;
  logic [3:0]       rn;
  uopState_t        tailFirst, tailAfterBase, tailAfterWb;

  assign isBlk    = InstrD[CLASS_HI:CLASS_LO] == CLASS_BLK;
  assign blkL     = InstrD[BIT_L];
  assign blkW     = InstrD[BIT_W];
  assign rn       = InstrD[19:16];
  assign regList  = InstrD[NREGS-1:0];
  // Loads defer Rn and R15 so the base is read intact and the branch comes last.
  assign xferList = blkL ? (regList & ~((NREGS'(1) << rn) | (NREGS'(1) << PC_IDX))) : regList;

  assign needBase      = blkL && regList[rn];
  assign needWb        = blkW && !needBase;
  assign needPc        = blkL && regList[PC_IDX];
  assign tailAfterWb   = needPc ? PCLD : READY;
  assign tailAfterBase = needWb ? WB : tailAfterWb;
  assign tailFirst     = needBase ? BASE : tailAfterBase;

  assign pickIn = (state == XFER) ? maskQ : xferList;

  uop_reglist_picker picker (
    .mask     (pickIn),
    .idx      (pickIdx),
    .valid    (pickValid),
    .maskRest (pickRest)
  );

  // Remaining transfer mask: cleared on reset or flush, frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset || FlushD) maskQ <= '0;
    else if (!StallD)    maskQ <= maskNext;
  end
`endif

  // State register: reset > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (reset || FlushD) state <= READY;
    else if (!StallD)    state <= stateNext;
  end

  // Pick the emitting stage, build the micro-op and compute the next state.
  always_comb begin
    stage            = state;
    stateNext        = READY;
    uOpInstrD        = InstrD;
    doNotUpdateFlagD = 1'b0;
    prevRSRstateD    = 1'b0;
`ifdef UOP_LDM_STM_EN
    maskNext = '0;
    emitXfer = 1'b0;
    emitWb   = 1'b0;
    emitRd   = pickIdx;
    if (state == READY && isBlk && regList != '0)
      stage = pickValid ? XFER : tailFirst;
`endif
    case (stage)
      READY: begin
        if (isRsr) begin
          doNotUpdateFlagD = 1'b1;
          stateNext        = RSR2;
        end
`ifdef UOP_LDM_STM_EN
        else if (isBlk) begin
          uOpInstrD = {InstrD[31:28], NOP_BODY};
        end
`endif
      end
      RSR2: begin
        prevRSRstateD    = 1'b1;
        doNotUpdateFlagD = !InstrD[BIT_S];
      end
`ifdef UOP_LDM_STM_EN
      XFER: begin
        emitXfer  = 1'b1;
        maskNext  = pickRest;
        stateNext = (pickRest != '0) ? XFER : tailFirst;
      end
      BASE: begin
        emitXfer  = 1'b1;
        emitRd    = rn;
        stateNext = tailAfterBase;
      end
      WB: begin
        emitWb    = 1'b1;
        stateNext = tailAfterWb;
      end
      PCLD: begin
        emitXfer = 1'b1;
        emitRd   = IDX_W'(PC_IDX);
      end
`endif
      default: ;
    endcase
`ifdef UOP_LDM_STM_EN
    if (emitXfer)    uOpInstrD = blkXferUop(InstrD, emitRd);
    else if (emitWb) uOpInstrD = blkWbUop(InstrD);
`endif
  end

  assign uOpStallD  = stateNext != READY;
  assign uOpActiveD = state != READY;

endmodule
